// File: rtl/conv2d_window_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_window_stream
// Purpose  : Converts a raster-order pixel stream into KxK windows for the
//            2D convolution MAC array. It keeps K-1 rows of history in
//            shift-chain line buffers and a KxK window register. Valid/ready
//            flow control is applied on both sides. Edge positions where no
//            full window exists are dropped.
// Ports    : clock, reset_n (async, active low)
//            in_valid / in_ready / in_data       - pixel input, raster order
//            out_valid / out_ready / out_window  - window output, where
//                element (r,c) is at [(r*K+c)*bitWidth +: bitWidth]
//            out_row / out_col  - image position of the window's
//                                 bottom-right pixel
//            frame_done         - one-cycle pulse after the last pixel of a
//                                 frame is accepted
//            in_sof / sync_err  - present only when CONV2D_SOF_SYNC_EN is
//                                 defined: start-of-frame marker in, and a
//                                 sticky framing error out
// Options  : CONV2D_SOF_SYNC_EN - enables start-of-frame resynchronisation
// Revision : 1.0 - initial release
// ============================================================================
module conv2d_window_stream #(
  parameter int filtDimension = 3,
  parameter int bitWidth      = 8,
  parameter int inputWidth    = 8,
  parameter int inputHeight   = 8
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
`ifdef CONV2D_SOF_SYNC_EN
  input  logic                                          in_sof,
  output logic                                          sync_err,
`endif
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [bitWidth-1:0]                    in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [filtDimension*filtDimension*bitWidth-1:0] out_window,
  output logic [$clog2(inputHeight)-1:0]                out_row,
  output logic [$clog2(inputWidth)-1:0]                 out_col,
  output logic                                          frame_done
);

  localparam int c_K     = filtDimension;
  localparam int c_BW    = bitWidth;
  localparam int c_DEPTH = inputWidth - filtDimension;
  localparam int c_RW    = $clog2(inputHeight);
  localparam int c_CW    = $clog2(inputWidth);
  localparam int c_WINW  = c_K * c_K * c_BW;

  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(inputHeight - 1);
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(inputWidth - 1);
  localparam logic [c_RW-1:0] c_ROW_MIN  = c_RW'(filtDimension - 1);
  localparam logic [c_CW-1:0] c_COL_MIN  = c_CW'(filtDimension - 1);

  // --------------------------------------------------------------------------
  // Handshake: there is a single output register and no skid buffer.
  // --------------------------------------------------------------------------
  logic r_out_valid;
  logic w_accept;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Position of the pixel being accepted and the next counter state
  // --------------------------------------------------------------------------
  logic [c_RW-1:0] r_row, w_pos_row, w_row_nxt;
  logic [c_CW-1:0] r_col, w_pos_col, w_col_nxt;
  logic            w_last_row, w_last_col;
  logic            w_emit, w_frame_end;
`ifdef CONV2D_SOF_SYNC_EN
  logic            w_sync_hit;
`endif

  always_comb begin
    w_pos_row  = r_row;
    w_pos_col  = r_col;
`ifdef CONV2D_SOF_SYNC_EN
    // An SOF pixel is always treated as (0,0). An SOF away from (0,0), or a
    // (0,0) pixel without SOF, flags a framing error.
    w_sync_hit = 1'b0;
    if (in_sof) begin
      w_pos_row  = '0;
      w_pos_col  = '0;
      w_sync_hit = (r_row != '0) || (r_col != '0);
    end else begin
      w_sync_hit = (r_row == '0) && (r_col == '0);
    end
`endif
    w_last_row = (w_pos_row == c_ROW_LAST);
    w_last_col = (w_pos_col == c_COL_LAST);
    if (w_last_col) begin
      w_col_nxt = '0;
      w_row_nxt = w_last_row ? '0 : w_pos_row + c_RW'(1);
    end else begin
      w_col_nxt = w_pos_col + c_CW'(1);
      w_row_nxt = w_pos_row;
    end
    // A window exists only once K-1 rows and K-1 columns precede the pixel.
    // This gating also hides stale line-buffer data from the previous frame.
    w_emit      = w_accept && (w_pos_row >= c_ROW_MIN) && (w_pos_col >= c_COL_MIN);
    w_frame_end = w_accept && w_last_row && w_last_col;
  end

  // --------------------------------------------------------------------------
  // Window register and line buffers (data path, no reset)
  // --------------------------------------------------------------------------
  logic [c_BW-1:0] r_win    [c_K][c_K];
  logic [c_BW-1:0] w_next   [c_K][c_K];
  logic [c_BW-1:0] w_lb_out [c_K-1];
  logic [c_WINW-1:0] w_next_flat;

  // On accept every window row shifts left by one. The bottom row takes the
  // new pixel. Each upper row takes the pixel leaving the row below it,
  // delayed through a (W-K)-deep chain. The total delay is therefore one
  // image row: K window columns plus W-K chain stages.
  always_comb begin
    for (int r = 0; r < c_K; r++) begin
      for (int c = 0; c < c_K - 1; c++) begin
        w_next[r][c] = r_win[r][c+1];
      end
    end
    for (int r = 0; r < c_K - 1; r++) begin
      w_next[r][c_K-1] = w_lb_out[r];
    end
    w_next[c_K-1][c_K-1] = in_data;
  end

  always_comb begin
    w_next_flat = '0;
    for (int r = 0; r < c_K; r++) begin
      for (int c = 0; c < c_K; c++) begin
        w_next_flat[(r*c_K+c)*c_BW +: c_BW] = w_next[r][c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int r = 0; r < c_K; r++) begin
        for (int c = 0; c < c_K; c++) begin
          r_win[r][c] <= w_next[r][c];
        end
      end
    end
  end

  for (genvar gr = 0; gr < c_K - 1; gr++) begin : g_line
    if (c_DEPTH > 0) begin : g_srl
      logic [c_BW-1:0] r_lb [c_DEPTH];
      always_ff @(posedge clock) begin
        if (w_accept) begin
          r_lb[0] <= r_win[gr+1][0];
          for (int i = 1; i < c_DEPTH; i++) begin
            r_lb[i] <= r_lb[i-1];
          end
        end
      end
      assign w_lb_out[gr] = r_lb[c_DEPTH-1];
    end else begin : g_direct
      // When W == K, the window columns alone provide the full row delay.
      assign w_lb_out[gr] = r_win[gr+1][0];
    end
  end

  // --------------------------------------------------------------------------
  // Control and output registers
  // --------------------------------------------------------------------------
  logic [c_WINW-1:0] r_out_window;
  logic [c_RW-1:0]   r_out_row;
  logic [c_CW-1:0]   r_out_col;
  logic              r_frame_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_row        <= '0;
      r_col        <= '0;
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_accept) begin
        r_row <= w_row_nxt;
        r_col <= w_col_nxt;
      end
      // A new window may load only when the register is free or is being
      // drained in this cycle, because w_accept already implies in_ready.
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_window <= w_next_flat;
        r_out_row    <= w_pos_row;
        r_out_col    <= w_pos_col;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

`ifdef CONV2D_SOF_SYNC_EN
  logic r_sync_err;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_err <= 1'b0;
    end else if (w_accept && w_sync_hit) begin
      r_sync_err <= 1'b1;
    end
  end
  assign sync_err = r_sync_err;
`endif

  assign out_valid  = r_out_valid;
  assign out_window = r_out_window;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_window_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2d_window_stream
// Purpose  : Directed self-checking bench for conv2d_window_stream
//            (K=3, W=8, H=8, 8-bit pixels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv2d_window_stream;

  localparam int K  = 3;
  localparam int BW = 8;
  localparam int W  = 8;
  localparam int H  = 8;

  logic            clock     = 1'b0;
  logic            reset_n   = 1'b0;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b1;
  logic [BW-1:0]   in_data   = '0;
  logic            in_ready;
  logic            out_valid;
  logic            frame_done;
  logic [K*K*BW-1:0] out_window;
  logic [2:0]      out_row;
  logic [2:0]      out_col;
`ifdef CONV2D_SOF_SYNC_EN
  logic            in_sof = 1'b0;
  logic            sync_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [71:0] win_q[$];
  logic [71:0] ref_q[$];
  int          row_q[$];
  int          col_q[$];
  int          fd_count;
  int          stall_cycles;
  int          stall_bad_val;
  int          stall_bad_rdy;
  int          first_acc;
  logic        se_before;
  logic        se_after;

  always #5 clock = ~clock;

  conv2d_window_stream #(
    .filtDimension(K),
    .bitWidth     (BW),
    .inputWidth   (W),
    .inputHeight  (H)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
`ifdef CONV2D_SOF_SYNC_EN
    .in_sof    (in_sof),
    .sync_err  (sync_err),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_window(out_window),
    .out_row   (out_row),
    .out_col   (out_col),
    .frame_done(frame_done)
  );

  // Window of a frame whose pixel (r,c) has value base + r*8 + c, with its
  // bottom-right corner at (r0,c0).
  function automatic logic [71:0] exp_win(input int base, input int r0, input int c0);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = 8'(base + (r0 - 2 + r) * 8 + (c0 - 2 + c));
    return w;
  endfunction

  // Nine literal element values in (r,c) row-major order.
  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    int v[9];
    logic [71:0] w;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4;
    v[5] = a5; v[6] = a6; v[7] = a7; v[8] = a8;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(v[i]);
    return w;
  endfunction

  // This task streams npix pixels. Pixels below index 64 come from base0 and
  // the rest from base1. It records output handshakes, frame_done pulses and
  // the state during a stall. The stall holds out_ready low for 5 cycles once
  // the third window is valid.
  task automatic drive(input int npix, input int base0, input int base1,
                       input bit rnd, input bit stall, input int sof_idx);
    int   idx;
    int   cyc;
    int   stall_left;
    int   drain;
    bit   stall_done;
    bit   done;
    logic [71:0] hold_exp;
    idx = 0; cyc = 0; stall_left = 0; drain = 6; stall_done = 0; done = 0;
    hold_exp = pack9(2, 3, 4, 10, 11, 12, 18, 19, 20);
    win_q.delete(); row_q.delete(); col_q.delete();
    fd_count = 0; stall_cycles = 0; stall_bad_val = 0; stall_bad_rdy = 0;
    first_acc = -1; se_before = 1'bx; se_after = 1'bx;
    while (!done) begin
      @(posedge clock); #1;
      if (idx < npix) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = 8'((idx < 64) ? base0 + idx : base1 + idx - 64);
      end else begin
        in_valid = 1'b0;
      end
`ifdef CONV2D_SOF_SYNC_EN
      in_sof = (idx == 0) || (idx == sof_idx) || (sof_idx < 0 && idx == 64);
`endif
      out_ready = 1'b1;
      if (stall && !stall_done && out_valid && win_q.size() == 2) begin
        stall_left = 5;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        stall_cycles++;
      end
      @(negedge clock);
      if (!out_ready) begin
        if (out_window !== hold_exp) stall_bad_val++;
        if (in_ready !== 1'b0) stall_bad_rdy++;
      end
      if (out_valid && first_acc < 0) first_acc = idx;
`ifdef CONV2D_SOF_SYNC_EN
      if (in_valid && idx == sof_idx) se_before = sync_err;
      if (idx == sof_idx + 1 && se_after === 1'bx) se_after = sync_err;
`endif
      if (out_valid && out_ready) begin
        win_q.push_back(out_window);
        row_q.push_back(int'(out_row));
        col_q.push_back(int'(out_col));
      end
      if (frame_done) fd_count++;
      if (in_valid && in_ready) idx++;
      cyc++;
      if (idx >= npix) drain--;
      if (drain == 0) done = 1;
      if (cyc >= 3000) begin
        checks++; failures++;
        $display("FAIL drive_timeout accepted=%0d required=%0d", idx, npix);
        done = 1;
      end
    end
    in_valid = 1'b0;
`ifdef CONV2D_SOF_SYNC_EN
    in_sof = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    checks++; if (out_window !== '0) begin failures++; $display("FAIL rst_out_window got=%h exp=0", out_window); end
    checks++; if (out_row !== 3'd0 || out_col !== 3'd0) begin failures++; $display("FAIL rst_out_pos got=%0d,%0d exp=0,0", out_row, out_col); end
`ifdef CONV2D_SOF_SYNC_EN
    checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL rst_sync_err got=%b exp=0", sync_err); end
`endif
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream();
    drive(64, 0, 64, 0, 0, -1);
    checks++; if (win_q.size() != 36) begin failures++; $display("FAIL stream_count got=%0d exp=36", win_q.size()); end
    if (win_q.size() == 36) begin
      checks++; if (win_q[0] !== pack9(0, 1, 2, 8, 9, 10, 16, 17, 18)) begin failures++; $display("FAIL stream_first got=%h exp=%h", win_q[0], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18)); end
      checks++; if (row_q[0] != 2 || col_q[0] != 2) begin failures++; $display("FAIL stream_first_pos got=%0d,%0d exp=2,2", row_q[0], col_q[0]); end
      checks++; if (win_q[35] !== pack9(45, 46, 47, 53, 54, 55, 61, 62, 63)) begin failures++; $display("FAIL stream_last got=%h exp=%h", win_q[35], pack9(45, 46, 47, 53, 54, 55, 61, 62, 63)); end
      checks++; if (row_q[35] != 7 || col_q[35] != 7) begin failures++; $display("FAIL stream_last_pos got=%0d,%0d exp=7,7", row_q[35], col_q[35]); end
      for (int i = 0; i < 36; i++) begin
        checks++;
        if (win_q[i] !== exp_win(0, 2 + i / 6, 2 + i % 6) || row_q[i] != 2 + i / 6 || col_q[i] != 2 + i % 6) begin
          failures++;
          $display("FAIL stream_win%0d got=%h@%0d,%0d exp=%h@%0d,%0d", i, win_q[i], row_q[i], col_q[i],
                   exp_win(0, 2 + i / 6, 2 + i % 6), 2 + i / 6, 2 + i % 6);
        end
      end
    end
    checks++; if (fd_count != 1) begin failures++; $display("FAIL stream_frame_done got=%0d exp=1", fd_count); end
    ref_q = win_q;
  endtask

  task automatic test_backpressure();
    drive(64, 0, 64, 0, 1, -1);
    checks++; if (stall_cycles != 5) begin failures++; $display("FAIL bp_stall_len got=%0d exp=5", stall_cycles); end
    checks++; if (stall_bad_val != 0) begin failures++; $display("FAIL bp_hold_window bad_cycles=%0d exp=0", stall_bad_val); end
    checks++; if (stall_bad_rdy != 0) begin failures++; $display("FAIL bp_in_ready bad_cycles=%0d exp=0", stall_bad_rdy); end
    checks++; if (win_q.size() != 36) begin failures++; $display("FAIL bp_count got=%0d exp=36", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < 36; i++) begin
      checks++;
      if (win_q[i] !== exp_win(0, 2 + i / 6, 2 + i % 6)) begin
        failures++;
        $display("FAIL bp_win%0d got=%h exp=%h", i, win_q[i], exp_win(0, 2 + i / 6, 2 + i % 6));
      end
    end
  endtask

  task automatic test_random_valid();
    drive(64, 0, 64, 1, 0, -1);
    checks++; if (win_q.size() != 36) begin failures++; $display("FAIL rnd_count got=%0d exp=36", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < ref_q.size(); i++) begin
      checks++;
      if (win_q[i] !== exp_win(0, 2 + i / 6, 2 + i % 6)) begin
        failures++;
        $display("FAIL rnd_win%0d got=%h exp=%h", i, win_q[i], exp_win(0, 2 + i / 6, 2 + i % 6));
      end
    end
    checks++; if (fd_count != 1) begin failures++; $display("FAIL rnd_frame_done got=%0d exp=1", fd_count); end
  endtask

  task automatic test_reset_midframe();
    drive(31, 0, 64, 0, 0, -1);
    checks++; if (win_q.size() != 11) begin failures++; $display("FAIL mid_partial_count got=%0d exp=11", win_q.size()); end
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_window !== '0) begin failures++; $display("FAIL mid_rst_out_window got=%h exp=0", out_window); end
    repeat (2) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_hold_valid got=%b exp=0", out_valid); end
    reset_n = 1'b1;
    drive(64, 0, 64, 0, 0, -1);
    checks++; if (win_q.size() != 36) begin failures++; $display("FAIL mid_count got=%0d exp=36", win_q.size()); end
    if (win_q.size() > 0) begin
      checks++; if (win_q[0] !== pack9(0, 1, 2, 8, 9, 10, 16, 17, 18)) begin failures++; $display("FAIL mid_first got=%h exp=%h", win_q[0], pack9(0, 1, 2, 8, 9, 10, 16, 17, 18)); end
      checks++; if (row_q[0] != 2 || col_q[0] != 2) begin failures++; $display("FAIL mid_first_pos got=%0d,%0d exp=2,2", row_q[0], col_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    drive(128, 0, 100, 0, 0, -1);
    checks++; if (win_q.size() != 72) begin failures++; $display("FAIL b2b_count got=%0d exp=72", win_q.size()); end
    checks++; if (fd_count != 2) begin failures++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_count); end
    if (win_q.size() == 72) begin
      checks++; if (win_q[36] !== pack9(100, 101, 102, 108, 109, 110, 116, 117, 118)) begin failures++; $display("FAIL b2b_f2_first got=%h exp=%h", win_q[36], pack9(100, 101, 102, 108, 109, 110, 116, 117, 118)); end
      for (int i = 0; i < 72; i++) begin
        checks++;
        if (win_q[i] !== exp_win(i < 36 ? 0 : 100, 2 + (i % 36) / 6, 2 + i % 6)) begin
          failures++;
          $display("FAIL b2b_win%0d got=%h exp=%h", i, win_q[i], exp_win(i < 36 ? 0 : 100, 2 + (i % 36) / 6, 2 + i % 6));
        end
      end
    end
  endtask

`ifdef CONV2D_SOF_SYNC_EN
  task automatic test_sof();
    test_reset();
    drive(74, 0, 64, 0, 0, 10);
    checks++; if (se_before !== 1'b0) begin failures++; $display("FAIL sof_err_before got=%b exp=0", se_before); end
    checks++; if (se_after !== 1'b1) begin failures++; $display("FAIL sof_err_after got=%b exp=1", se_after); end
    checks++; if (first_acc != 29) begin failures++; $display("FAIL sof_first_latency got=%0d exp=29", first_acc); end
    checks++; if (win_q.size() != 36) begin failures++; $display("FAIL sof_count got=%0d exp=36", win_q.size()); end
    if (win_q.size() > 0) begin
      checks++; if (win_q[0] !== pack9(10, 11, 12, 18, 19, 20, 26, 27, 28)) begin failures++; $display("FAIL sof_first got=%h exp=%h", win_q[0], pack9(10, 11, 12, 18, 19, 20, 26, 27, 28)); end
    end
    checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL sof_sticky got=%b exp=1", sync_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random_valid();
    test_reset_midframe();
    test_back_to_back();
`ifdef CONV2D_SOF_SYNC_EN
    test_sof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
